// File: rtl/cg_iteration_sequencer.sv
// Control sequencer for one conjugate-gradient solve: starts each datapath stage in turn,
// waits on its finish under a watchdog, latches r.r values and applies the exit test.
module cg_iteration_sequencer #(
    parameter int ELEMENT_WIDTH  = 32,
    parameter int ITER_W         = 16,
    parameter int TIMEOUT_W      = 12,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic                     abort,
    input  logic                     mode_fixed,
    input  logic [ELEMENT_WIDTH-1:0] tol,
    input  logic [ITER_W-1:0]        max_iter,
    input  logic [8:0]               stage_finish,
    input  logic [ELEMENT_WIDTH-1:0] rs_in,
    output logic [8:0]               stage_start,
    output logic [ELEMENT_WIDTH-1:0] rsold,
    output logic [ELEMENT_WIDTH-1:0] rsnew,
    output logic [ITER_W-1:0]        iter_count,
    output logic                     busy,
    output logic                     done,
    output logic                     converged,
    output logic                     timeout_err
);

    localparam int MAN_W = ELEMENT_WIDTH - 9;
    localparam int MAG_W = ELEMENT_WIDTH - 1;

    localparam int B_RSOLD = 0;
    localparam int B_AP    = 1;
    localparam int B_PAP   = 2;
    localparam int B_ALPHA = 3;
    localparam int B_UPD_X = 4;
    localparam int B_UPD_R = 5;
    localparam int B_RSNEW = 6;
    localparam int B_BETA  = 7;
    localparam int B_UPD_P = 8;

    typedef enum logic [3:0] {
        ST_IDLE, ST_RSOLD, ST_AP, ST_PAP, ST_ALPHA, ST_UPD_XR,
        ST_RSNEW, ST_CHECK, ST_BETA, ST_UPD_P, ST_DONE, ST_ERR
    } state_t;

    state_t             state, state_next;
    logic               first;
    logic [TIMEOUT_W-1:0] wd;
    logic [1:0]         xr_seen;
    logic [MAG_W-1:0]   tol_q;
    logic [ITER_W-1:0]  max_iter_q;

    logic [8:0] fin;
    logic       in_stage, wd_expired;
    logic       load_go, load_rsold_in, load_rsnew, load_rsold_new, set_conv;
    logic       rs_in_lt, rsnew_lt;

    function automatic logic is_nan(input logic [ELEMENT_WIDTH-1:0] v);
        return (&v[ELEMENT_WIDTH-2 -: 8]) && (|v[MAN_W-1:0]);
    endfunction

    // Both operands are non-negative floats, so magnitude bits order like an unsigned integer.
    assign rs_in_lt = rs_in[MAG_W-1:0] < tol_q;
    assign rsnew_lt = rsnew[MAG_W-1:0] < tol_q;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE) || (state == ST_ERR);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next     = state;
        stage_start    = '0;
        load_go        = 1'b0;
        load_rsold_in  = 1'b0;
        load_rsnew     = 1'b0;
        load_rsold_new = 1'b0;
        set_conv       = 1'b0;
        fin            = first ? 9'd0 : stage_finish;
        in_stage       = state inside {ST_RSOLD, ST_AP, ST_PAP, ST_ALPHA, ST_UPD_XR,
                                       ST_RSNEW, ST_BETA, ST_UPD_P};
        wd_expired     = in_stage && (wd == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

        if (first) begin
            unique case (state)
                ST_RSOLD:  stage_start[B_RSOLD] = 1'b1;
                ST_AP:     stage_start[B_AP]    = 1'b1;
                ST_PAP:    stage_start[B_PAP]   = 1'b1;
                ST_ALPHA:  stage_start[B_ALPHA] = 1'b1;
                ST_UPD_XR: begin
                    stage_start[B_UPD_X] = 1'b1;
                    stage_start[B_UPD_R] = 1'b1;
                end
                ST_RSNEW:  stage_start[B_RSNEW] = 1'b1;
                ST_BETA:   stage_start[B_BETA]  = 1'b1;
                ST_UPD_P:  stage_start[B_UPD_P] = 1'b1;
                default:   stage_start = '0;
            endcase
        end

        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (go) begin
                    load_go    = 1'b1;
                    state_next = (max_iter == '0) ? ST_DONE : ST_RSOLD;
                end
                ST_RSOLD: if (fin[B_RSOLD]) begin
                    load_rsold_in = 1'b1;
                    if (is_nan(rs_in)) begin
                        state_next = ST_ERR;
                    end else if (!mode_fixed && rs_in_lt) begin
                        set_conv   = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_AP;
                    end
                end
                ST_AP:     if (fin[B_AP])    state_next = ST_PAP;
                ST_PAP:    if (fin[B_PAP])   state_next = ST_ALPHA;
                ST_ALPHA:  if (fin[B_ALPHA]) state_next = ST_UPD_XR;
                ST_UPD_XR: if ((xr_seen | fin[B_UPD_R:B_UPD_X]) == 2'b11) state_next = ST_RSNEW;
                ST_RSNEW: if (fin[B_RSNEW]) begin
                    load_rsnew = 1'b1;
                    state_next = ST_CHECK;
                end
                ST_CHECK: begin
                    if (is_nan(rsnew)) begin
                        state_next = ST_ERR;
                    end else if (!mode_fixed && rsnew_lt) begin
                        set_conv   = 1'b1;
                        state_next = ST_DONE;
                    end else if (iter_count == max_iter_q) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_BETA;
                    end
                end
                ST_BETA: if (fin[B_BETA]) state_next = ST_UPD_P;
                ST_UPD_P: if (fin[B_UPD_P]) begin
                    load_rsold_new = 1'b1;
                    state_next     = ST_AP;
                end
                ST_DONE, ST_ERR: state_next = ST_IDLE;
                default:         state_next = ST_IDLE;
            endcase

            if (wd_expired && state_next == state) state_next = ST_ERR;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            first       <= 1'b0;
            wd          <= '0;
            xr_seen     <= '0;
            tol_q       <= '0;
            max_iter_q  <= '0;
            rsold       <= '0;
            rsnew       <= '0;
            iter_count  <= '0;
            converged   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            first <= (state_next != state);

            if (state_next != state) begin
                wd      <= '0;
                xr_seen <= '0;
            end else begin
                if (in_stage) wd <= wd + TIMEOUT_W'(1);
                if (state == ST_UPD_XR) xr_seen <= xr_seen | fin[B_UPD_R:B_UPD_X];
            end

            if (load_go) begin
                tol_q       <= tol[MAG_W-1:0];
                max_iter_q  <= max_iter;
                iter_count  <= '0;
                converged   <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (load_rsold_in)  rsold <= rs_in;
            if (load_rsold_new) rsold <= rsnew;
            if (load_rsnew) begin
                rsnew <= rs_in;
                if (iter_count != '1) iter_count <= iter_count + ITER_W'(1);
            end
            if (set_conv) converged <= 1'b1;
            if (state_next == ST_ERR && state != ST_ERR) begin
                timeout_err <= 1'b1;
                converged   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Scoreboard bench for cg_iteration_sequencer: a stage responder answers start pulses,
// a monitor pops expected start/done events and compares them as the DUT emits them.
module tb_cg_iteration_sequencer;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        reset, go, abort, mode_fixed;
    logic [31:0] tol, rs_in;
    logic [15:0] max_iter;
    logic [8:0]  stage_finish, stage_start;
    logic [31:0] rsold, rsnew;
    logic [15:0] iter_count;
    logic        busy, done, converged, timeout_err;

    cg_iteration_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort), .mode_fixed(mode_fixed),
        .tol(tol), .max_iter(max_iter), .stage_finish(stage_finish), .rs_in(rs_in),
        .stage_start(stage_start), .rsold(rsold), .rsnew(rsnew), .iter_count(iter_count),
        .busy(busy), .done(done), .converged(converged), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_done;
        logic [8:0]  starts;
        logic [15:0] iter;
        logic        conv;
        logic        terr;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0, n_total = 0;
    int          cyc = 0;
    int          dly[9];
    int          cnt[9];
    logic [31:0] rs_old_val;
    logic [31:0] rn_vals[4];
    int          rn_idx;
    int          xr_cyc, rsnew_cyc, pap_cyc, done_cyc, go_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Stage responder: each started stage finishes dly[b] cycles later (dly<=0 means never).
    initial begin
        stage_finish = '0;
        rs_in        = '0;
        for (int b = 0; b < 9; b++) cnt[b] = 0;
        forever begin
            @(negedge clk);
            stage_finish = '0;
            for (int b = 0; b < 9; b++) begin
                if (cnt[b] > 0) begin
                    cnt[b]--;
                    if (cnt[b] == 0) begin
                        stage_finish[b] = 1'b1;
                        if (b == 0) rs_in = rs_old_val;
                        if (b == 6) begin
                            rs_in = rn_vals[rn_idx % 4];
                            rn_idx++;
                        end
                    end
                end
            end
            for (int b = 0; b < 9; b++)
                if (stage_start[b] && dly[b] > 0) cnt[b] = dly[b];
        end
    end

    // Monitor: every start pulse or done pulse consumes one expected event.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset && (stage_start != '0 || done)) begin
            if (stage_start[4]) xr_cyc = cyc;
            if (stage_start[6]) rsnew_cyc = cyc;
            if (stage_start[2]) pap_cyc = cyc;
            if (done) done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_output", 64'({stage_start, done}), 64'd0);
            end else begin
                e = sb.pop_front();
                if (e.is_done) begin
                    check("done_flag", 64'({stage_start, done}), 64'd1);
                    check("done_iter", 64'(iter_count), 64'(e.iter));
                    check("done_converged", 64'(converged), 64'(e.conv));
                    check("done_timeout_err", 64'(timeout_err), 64'(e.terr));
                end else begin
                    check("start_order", 64'({stage_start, done}), 64'({e.starts, 1'b0}));
                end
            end
        end
    end

    task automatic push_start(input logic [8:0] b);
        exp_t e;
        e = '0;
        e.starts = b;
        sb.push_back(e);
    endtask

    task automatic push_done(input logic [15:0] it, input logic cv, input logic te);
        exp_t e;
        e = '0;
        e.is_done = 1'b1;
        e.iter    = it;
        e.conv    = cv;
        e.terr    = te;
        sb.push_back(e);
    endtask

    task automatic push_iter(input bit last);
        push_start(9'h002);
        push_start(9'h004);
        push_start(9'h008);
        push_start(9'h030);
        push_start(9'h040);
        if (!last) begin
            push_start(9'h080);
            push_start(9'h100);
        end
    endtask

    task automatic set_dly(input int d);
        for (int b = 0; b < 9; b++) dly[b] = d;
    endtask

    task automatic start_run(input logic mf, input logic [31:0] t, input logic [15:0] mi,
                             input logic [31:0] rso);
        @(negedge clk);
        mode_fixed = mf;
        tol        = t;
        max_iter   = mi;
        rs_old_val = rso;
        rn_idx     = 0;
        go         = 1'b1;
        go_cyc     = cyc;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_wait_expired", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_start(input int b, input int budget);
        int n = 0;
        while (!stage_start[b] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!stage_start[b]) check("start_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rsold"}, 64'(rsold), 64'd0);
        check({tag, "_rsnew"}, 64'(rsnew), 64'd0);
        check({tag, "_iter"}, 64'(iter_count), 64'd0);
        check({tag, "_ctrl"}, 64'({stage_start, busy, done, converged, timeout_err}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        reset = 1'b0; go = 1'b0; abort = 1'b0; mode_fixed = 1'b0;
        tol = '0; max_iter = '0; rs_old_val = '0; rn_idx = 0;
        rn_vals = '{32'h0, 32'h0, 32'h0, 32'h0};
        set_dly(5);
        #12;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        settle(2);

        // Fixed-mode run of three iterations, stages finish 5 cycles after start.
        rn_vals = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h0};
        push_start(9'h001);
        push_iter(0);
        push_iter(0);
        push_iter(1);
        push_done(16'd3, 1'b0, 1'b0);
        start_run(1'b1, 32'h0, 16'd3, 32'h3F80_0000);
        wait_done(2000);
        settle(3);
        check("t1_drained", 64'(sb.size()), 64'd0);
        check("t1_rsold", 64'(rsold), 64'h4040_0000);
        check("t1_rsnew", 64'(rsnew), 64'h4080_0000);
        check("t1_busy", 64'(busy), 64'd0);

        // Tolerance exit after iteration 2; a go while busy must be ignored.
        rn_vals = '{32'h3F00_0000, 32'h2000_0000, 32'h0, 32'h0};
        push_start(9'h001);
        push_iter(0);
        push_iter(1);
        push_done(16'd2, 1'b1, 1'b0);
        start_run(1'b0, 32'h2834_24DC, 16'd10, 32'h3F80_0000);
        settle(3);
        go = 1'b1;
        max_iter = 16'd0;
        @(negedge clk);
        go = 1'b0;
        wait_done(2000);
        settle(3);
        check("t2_drained", 64'(sb.size()), 64'd0);
        check("t2_converged_held", 64'(converged), 64'd1);
        check("t2_rsnew", 64'(rsnew), 64'h2000_0000);

        // UPD_X finishes 3 cycles after UPD_R.
        set_dly(2);
        dly[5] = 2;
        dly[4] = 5;
        rn_vals = '{32'h3F80_0000, 32'h0, 32'h0, 32'h0};
        push_start(9'h001);
        push_iter(1);
        push_done(16'd1, 1'b0, 1'b0);
        start_run(1'b1, 32'h0, 16'd1, 32'h3F80_0000);
        wait_done(500);
        settle(3);
        check("t3_drained", 64'(sb.size()), 64'd0);
        check("t3_xr_skewed_gap", 64'(rsnew_cyc - xr_cyc), 64'd6);

        // UPD_X and UPD_R finish on the same cycle.
        dly[4] = 3;
        dly[5] = 3;
        push_start(9'h001);
        push_iter(1);
        push_done(16'd1, 1'b0, 1'b0);
        start_run(1'b1, 32'h0, 16'd1, 32'h3F80_0000);
        wait_done(500);
        settle(3);
        check("t3_drained_b", 64'(sb.size()), 64'd0);
        check("t3_xr_same_gap", 64'(rsnew_cyc - xr_cyc), 64'd4);

        // PAP finish withheld: watchdog error.
        set_dly(2);
        dly[2] = -1;
        push_start(9'h001);
        push_start(9'h002);
        push_start(9'h004);
        push_done(16'd0, 1'b0, 1'b1);
        start_run(1'b1, 32'h0, 16'd5, 32'h3F80_0000);
        wait_done(500);
        settle(5);
        check("t4_drained", 64'(sb.size()), 64'd0);
        check("t4_timeout_gap", 64'(done_cyc - pap_cyc), 64'(TO));
        check("t4_err_sticky", 64'(timeout_err), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);

        // max_iter=0: immediate done, no stage started; go clears the sticky error.
        set_dly(2);
        push_done(16'd0, 1'b0, 1'b0);
        start_run(1'b1, 32'h0, 16'd0, 32'h3F80_0000);
        check("t6_err_cleared", 64'(timeout_err), 64'd0);
        wait_done(50);
        check("t6_done_latency", 64'(done_cyc - go_cyc), 64'd1);
        settle(3);
        check("t6_drained", 64'(sb.size()), 64'd0);

        // NaN rsnew goes to ERR.
        rn_vals = '{32'h7FC0_0000, 32'h0, 32'h0, 32'h0};
        push_start(9'h001);
        push_iter(1);
        push_done(16'd1, 1'b0, 1'b1);
        start_run(1'b1, 32'h0, 16'd3, 32'h3F80_0000);
        wait_done(500);
        settle(3);
        check("t6_nan_drained", 64'(sb.size()), 64'd0);
        check("t6_nan_rsnew", 64'(rsnew), 64'h7FC0_0000);

        // Abort during ALPHA; its late finish arrives in IDLE and must be ignored.
        set_dly(3);
        dly[3] = 6;
        push_start(9'h001);
        push_start(9'h002);
        push_start(9'h004);
        push_start(9'h008);
        start_run(1'b1, 32'h0, 16'd3, 32'h3F80_0000);
        wait_start(3, 300);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_busy", 64'(busy), 64'd0);
        settle(12);
        check("t5_abort_idle", 64'(busy), 64'd0);
        check("t5_abort_drained", 64'(sb.size()), 64'd0);

        // Asynchronous reset while waiting in UPD_P.
        set_dly(2);
        dly[8] = 10;
        rn_vals = '{32'h4000_0000, 32'h0, 32'h0, 32'h0};
        push_start(9'h001);
        push_iter(0);
        start_run(1'b1, 32'h0, 16'd3, 32'h3F80_0000);
        wait_start(8, 300);
        @(negedge clk);
        check("t5_updp_drained", 64'(sb.size()), 64'd0);
        check("t5_updp_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        reset = 1'b1;
        settle(15);
        check("t5_post_reset_idle", 64'(busy), 64'd0);
        check("t5_post_reset_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
